// File: rtl/snn_pkg.sv
// Shared SNN definitions: classifier FSM states and index-width helper.
package snn_pkg;

  // Winner-take-all window classifier states.
  typedef enum logic [1:0] {
    WTA_IDLE    = 2'd0,
    WTA_COUNT   = 2'd1,
    WTA_COMPARE = 2'd2,
    WTA_DONE    = 2'd3
  } wta_state_t;

  // Bits needed to index n items; never less than one bit so that a
  // single-item configuration still has a legal vector width.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/spike_counter_sat.sv
// Per-node spike counter: synchronous clear, gated increment, saturating at all-ones.
module spike_counter_sat #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;

  // Counter register: clear wins over increment; stick at CNT_MAX instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && inc_i && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1'b1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/wta_window_classifier.sv
// Winner-take-all classifier: counts spikes per node over a fixed window,
// then scans the counters serially to pick the lowest-index maximum.
module wta_window_classifier
  import snn_pkg::*;
#(
  parameter int NUM_NODES  = 4,
  parameter int CNT_W      = 8,
  parameter int WINDOW_LEN = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic [NUM_NODES-1:0]                 nodes_i,
  input  logic                                 ready_i,
  output logic                                 busy_o,
  output logic                                 valid_o,
  output logic [idx_width(NUM_NODES)-1:0]      winner_o,
  output logic [CNT_W-1:0]                     win_count_o,
  output logic                                 tie_o,
  output logic                                 none_o
);

  localparam int IDX_W = idx_width(NUM_NODES);
  localparam int TMR_W = idx_width(WINDOW_LEN);

  wta_state_t       r_state;
  wta_state_t       w_state_nxt;

  logic [TMR_W-1:0] r_tmr;
  logic [IDX_W-1:0] r_scan;

  logic [CNT_W-1:0] r_best_cnt;
  logic [IDX_W-1:0] r_best_idx;
  logic             r_best_tie;

  logic [CNT_W-1:0] w_best_cnt_nxt;
  logic [IDX_W-1:0] w_best_idx_nxt;
  logic             w_best_tie_nxt;

  logic             r_busy;
  logic             r_valid;
  logic [IDX_W-1:0] r_winner;
  logic [CNT_W-1:0] r_win_count;
  logic             r_tie;
  logic             r_none;

  logic             w_clr;
  logic             w_cnt_en;
  logic             w_last_sample;
  logic             w_last_scan;
  logic [CNT_W-1:0] w_scan_cnt;
  logic             w_take;
  logic [CNT_W-1:0] w_cnt [NUM_NODES];

  // Counters are wiped on the accepting start edge and only advance in COUNT.
  assign w_clr         = (r_state == WTA_IDLE) && start_i;
  assign w_cnt_en      = (r_state == WTA_COUNT);
  assign w_last_sample = (r_tmr == TMR_W'(WINDOW_LEN - 1));
  assign w_last_scan   = (r_scan == IDX_W'(NUM_NODES - 1));

  genvar g;
  generate
    for (g = 0; g < NUM_NODES; g++) begin : g_node
      spike_counter_sat #(
        .CNT_W (CNT_W)
      ) u_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (w_clr),
        .en_i   (w_cnt_en),
        .inc_i  (nodes_i[g]),
        .cnt_o  (w_cnt[g])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= WTA_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start_i is only looked at in IDLE, so there is no abort path.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WTA_IDLE: begin
        if (start_i) begin
          w_state_nxt = WTA_COUNT;
        end else begin
          w_state_nxt = WTA_IDLE;
        end
      end
      WTA_COUNT: begin
        if (w_last_sample) begin
          w_state_nxt = WTA_COMPARE;
        end else begin
          w_state_nxt = WTA_COUNT;
        end
      end
      WTA_COMPARE: begin
        if (w_last_scan) begin
          w_state_nxt = WTA_DONE;
        end else begin
          w_state_nxt = WTA_COMPARE;
        end
      end
      WTA_DONE: begin
        if (ready_i) begin
          w_state_nxt = WTA_IDLE;
        end else begin
          w_state_nxt = WTA_DONE;
        end
      end
      default: begin
        w_state_nxt = WTA_IDLE;
      end
    endcase
  end

  // Window timer counts COUNT edges; scan pointer walks the nodes during COMPARE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmr  <= '0;
      r_scan <= '0;
    end else begin
      case (r_state)
        WTA_COUNT: begin
          r_scan <= '0;
          if (w_last_sample) begin
            r_tmr <= '0;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1'b1);
          end
        end
        WTA_COMPARE: begin
          r_tmr <= '0;
          if (w_last_scan) begin
            r_scan <= '0;
          end else begin
            r_scan <= r_scan + IDX_W'(1'b1);
          end
        end
        default: begin
          r_tmr  <= '0;
          r_scan <= '0;
        end
      endcase
    end
  end

  // Node 0 always seeds the running best; later nodes replace it only when
  // strictly greater, so ties keep the lower index and just raise the tie flag.
  assign w_scan_cnt = w_cnt[r_scan];
  assign w_take     = (r_scan == '0) || (w_scan_cnt > r_best_cnt);

  // Running-best update for the node currently under the scan pointer.
  always_comb begin
    w_best_cnt_nxt = r_best_cnt;
    w_best_idx_nxt = r_best_idx;
    w_best_tie_nxt = r_best_tie;
    if (w_take) begin
      w_best_cnt_nxt = w_scan_cnt;
      w_best_idx_nxt = r_scan;
      w_best_tie_nxt = 1'b0;
    end else if (w_scan_cnt == r_best_cnt) begin
      w_best_tie_nxt = 1'b1;
    end else begin
      w_best_tie_nxt = r_best_tie;
    end
  end

  // Running-best registers advance only while scanning.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_best_cnt <= '0;
      r_best_idx <= '0;
      r_best_tie <= 1'b0;
    end else if (r_state == WTA_COMPARE) begin
      r_best_cnt <= w_best_cnt_nxt;
      r_best_idx <= w_best_idx_nxt;
      r_best_tie <= w_best_tie_nxt;
    end else begin
      r_best_cnt <= r_best_cnt;
      r_best_idx <= r_best_idx;
      r_best_tie <= r_best_tie;
    end
  end

  // Registered outputs: status flags follow the next state; the result is
  // captured on the final scan edge and held until the next capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_winner    <= '0;
      r_win_count <= '0;
      r_tie       <= 1'b0;
      r_none      <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt != WTA_IDLE);
      r_valid <= (w_state_nxt == WTA_DONE);
      if ((r_state == WTA_COMPARE) && w_last_scan) begin
        if (w_best_cnt_nxt == '0) begin
          r_winner    <= '0;
          r_win_count <= '0;
          r_tie       <= 1'b0;
          r_none      <= 1'b1;
        end else begin
          r_winner    <= w_best_idx_nxt;
          r_win_count <= w_best_cnt_nxt;
          r_tie       <= w_best_tie_nxt;
          r_none      <= 1'b0;
        end
      end else begin
        r_winner    <= r_winner;
        r_win_count <= r_win_count;
        r_tie       <= r_tie;
        r_none      <= r_none;
      end
    end
  end

  assign busy_o      = r_busy;
  assign valid_o     = r_valid;
  assign winner_o    = r_winner;
  assign win_count_o = r_win_count;
  assign tie_o       = r_tie;
  assign none_o      = r_none;

endmodule

// File: tb/tb_wta_window_classifier.sv
// Scoreboard bench: two instances (4-bit and 3-bit counters) share stimulus;
// the stimulus process queues hand-computed results, a monitor checks them.
module tb_wta_window_classifier;

  localparam int PER = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ready;
  logic [3:0] nodes;

  logic       busy_a, valid_a, tie_a, none_a;
  logic [1:0] win_a;
  logic [3:0] cnt_a;
  logic       busy_b, valid_b, tie_b, none_b;
  logic [1:0] win_b;
  logic [2:0] cnt_b;

  always #5 clk = ~clk;

  wta_window_classifier #(.NUM_NODES(4), .CNT_W(4), .WINDOW_LEN(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .nodes_i(nodes), .ready_i(ready),
    .busy_o(busy_a), .valid_o(valid_a), .winner_o(win_a), .win_count_o(cnt_a),
    .tie_o(tie_a), .none_o(none_a)
  );

  wta_window_classifier #(.NUM_NODES(4), .CNT_W(3), .WINDOW_LEN(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .nodes_i(nodes), .ready_i(ready),
    .busy_o(busy_b), .valid_o(valid_b), .winner_o(win_b), .win_count_o(cnt_b),
    .tie_o(tie_b), .none_o(none_b)
  );

  typedef struct {
    int  w;
    int  c;
    int  cb;
    int  t;
    int  n;
    time ts;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: on each rising valid, pop the oldest expected result and compare.
  always @(negedge clk) begin
    if ((valid_a === 1'b1) && (prev_valid !== 1'b1)) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("winner_a",  32'(win_a),  32'(mon_e.w));
        chk("count_a",   32'(cnt_a),  32'(mon_e.c));
        chk("tie_a",     32'(tie_a),  32'(mon_e.t));
        chk("none_a",    32'(none_a), 32'(mon_e.n));
        chk("valid_b",   32'(valid_b), 32'd1);
        chk("winner_b",  32'(win_b),  32'(mon_e.w));
        chk("count_b",   32'(cnt_b),  32'(mon_e.cb));
        chk("tie_b",     32'(tie_b),  32'(mon_e.t));
        chk("none_b",    32'(none_b), 32'(mon_e.n));
        chk("latency",   32'(int'(($time - mon_e.ts - 5) / PER)), 32'd12);
      end
    end
    prev_valid <= valid_a;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy_a"},  32'(busy_a),  32'd0);
    chk({tag, "_valid_a"}, 32'(valid_a), 32'd0);
    chk({tag, "_win_a"},   32'(win_a),   32'd0);
    chk({tag, "_cnt_a"},   32'(cnt_a),   32'd0);
    chk({tag, "_tie_a"},   32'(tie_a),   32'd0);
    chk({tag, "_none_a"},  32'(none_a),  32'd0);
    chk({tag, "_busy_b"},  32'(busy_b),  32'd0);
    chk({tag, "_valid_b"}, 32'(valid_b), 32'd0);
    chk({tag, "_win_b"},   32'(win_b),   32'd0);
    chk({tag, "_cnt_b"},   32'(cnt_b),   32'd0);
    chk({tag, "_tie_b"},   32'(tie_b),   32'd0);
    chk({tag, "_none_b"},  32'(none_b),  32'd0);
  endtask

  // Call just after a falling edge. pats holds one nibble per sample cycle, cycle 0 in bits [3:0].
  task automatic open_window(input logic [31:0] pats, input bit pulse,
                             input int w, input int c, input int cb, input int t, input int n);
    exp_t e;
    start = 1'b1;
    @(posedge clk);
    e.w = w; e.c = c; e.cb = cb; e.t = t; e.n = n; e.ts = $time;
    sb.push_back(e);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      nodes = pats[4*k +: 4];
    end
    @(negedge clk);
    nodes = 4'b0000;
    if (pulse) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_valid();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_a === 1'b1) break;
    end
    if (i == 40) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  // Ready held high: valid must drop after one cycle and the block return idle.
  task automatic finish_window();
    wait_valid();
    @(negedge clk);
    chk("one_cycle_valid", 32'(valid_a), 32'd0);
    chk("back_idle_busy",  32'(busy_a),  32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    nodes = 4'b0000;
    #12;
    chk_zero("reset");

    // Single winner; start already high at release, accepted on first edge.
    @(negedge clk);
    rst_n = 1'b1;
    open_window(32'h4444_4444, 1'b0, 2, 8, 7, 0, 0);
    finish_window();

    // Tie between nodes 1 and 3, node 0 lower.
    @(negedge clk);
    open_window(32'h000A_AABB, 1'b0, 1, 5, 5, 1, 0);
    finish_window();

    // Saturation: node 0 with 8 spikes (7 on 3-bit), node 1 with 6.
    @(negedge clk);
    open_window(32'h1133_3333, 1'b0, 0, 8, 7, 0, 0);
    finish_window();

    // No spikes.
    @(negedge clk);
    open_window(32'h0000_0000, 1'b0, 0, 0, 0, 0, 1);
    finish_window();

    // Backpressure, with a start pulse during COMPARE that must be ignored.
    ready = 1'b0;
    @(negedge clk);
    open_window(32'h0000_1888, 1'b1, 3, 3, 3, 0, 0);
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid",  32'(valid_a), 32'd1);
      chk("bp_winner", 32'(win_a),   32'd3);
      chk("bp_count",  32'(cnt_a),   32'd3);
      chk("bp_tie",    32'(tie_a),   32'd0);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(valid_a), 32'd0);
    chk("bp_release_busy",  32'(busy_a),  32'd0);
    @(negedge clk);
    chk("ignored_start_busy", 32'(busy_a), 32'd0);

    // Reset in the middle of COUNT, then a fresh window.
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      nodes = 4'b1111;
    end
    @(negedge clk);
    chk("held_winner", 32'(win_a),  32'd3);
    chk("held_count",  32'(cnt_a),  32'd3);
    chk("count_busy",  32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    @(negedge clk);
    nodes = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);
    open_window(32'h0000_0022, 1'b0, 1, 2, 2, 0, 0);
    finish_window();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wta_window_classifier.md
WTA_WINDOW_CLASSIFIER -- requirements
Module: wta_window_classifier

Interface
REQ-001 SHALL have parameter NUM_NODES, default 4: number of spike input channels, at least 2.
REQ-002 SHALL have parameter CNT_W, default 8: width of each per-node spike counter.
REQ-003 SHALL have parameter WINDOW_LEN, default 16: number of sample cycles per classification window, at least 1.
REQ-004 SHALL have port clk_i  in  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port start_i  in  1: opens a window; sampled only in IDLE.
REQ-007 SHALL have port nodes_i  in  NUM_NODES: one spike bit per node; sampled only in COUNT.
REQ-008 SHALL have port ready_i  in  1: consumer accepts the result.
REQ-009 SHALL have port busy_o  out  1: high in every state except IDLE.
REQ-010 SHALL have port valid_o  out  1: result valid; high only in DONE.
REQ-011 SHALL have port winner_o  out  clog2(NUM_NODES): index of the winning node.
REQ-012 SHALL have port win_count_o  out  CNT_W: spike count of the winning node.
REQ-013 SHALL have port tie_o  out  1: another node's count equalled the winning count.
REQ-014 SHALL have port none_o  out  1: all counts were zero.

Function
REQ-015 SHALL implement a four-state FSM: IDLE, COUNT, COMPARE, DONE.
REQ-016 IDLE SHALL go to COUNT on the edge that samples start_i=1, clearing all counters and the window timer on that edge.
REQ-017 COUNT SHALL last exactly WINDOW_LEN edges; on each, counter[i] increments by nodes_i[i] for every i.
REQ-018 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 COUNT SHALL go to COMPARE on its WINDOW_LEN-th edge, including that edge's sample.
REQ-020 COMPARE SHALL scan one node per edge, index 0 to NUM_NODES-1, for exactly NUM_NODES edges.
REQ-021 COMPARE SHALL replace the running best only on strictly greater count, so the lowest index wins ties.
REQ-022 During COMPARE, tie_o SHALL set when a scanned count equals the running best, and clear when a new best is taken.
REQ-023 After the last scan, none_o SHALL equal "best count is 0", and the FSM SHALL enter DONE.
REQ-024 When none_o=1, the module SHALL give winner_o=0, win_count_o=0 and tie_o=0.
REQ-025 valid_o SHALL rise on the (WINDOW_LEN+NUM_NODES)-th edge after the start edge.
REQ-026 In DONE, all result outputs SHALL hold stable until the edge where ready_i=1; that edge returns the FSM to IDLE.
REQ-027 If ready_i is already high on entry to DONE, valid_o SHALL still be high for exactly one cycle.
REQ-028 start_i SHALL be ignored outside IDLE; there is no abort and no overlap of windows.
REQ-029 Result outputs SHALL be registered, and SHALL keep the last result while in IDLE, COUNT and COMPARE until overwritten at the end of COMPARE.

Reset
REQ-030 Reset assertion SHALL immediately force state IDLE, counters 0, busy_o=0, valid_o=0, winner_o=0, win_count_o=0, tie_o=0 and none_o=0, from any state including mid-window.
REQ-031 After reset release, the first start_i=1 SHALL be accepted on the first rising edge.

Structure
REQ-032 The FSM state enum SHALL live in the shared SNN package (snn_pkg) as wta_state_t.
REQ-033 The index-width helper SHALL live in snn_pkg, so that NUM_NODES=1 still yields at least 1 bit.
REQ-034 The per-node saturating counter SHALL be a sub-module, spike_counter_sat, instantiated NUM_NODES times via generate.
REQ-035 Counter clear, enable and saturation SHALL be handled inside spike_counter_sat.

Verification (NUM_NODES=4, CNT_W=4, WINDOW_LEN=8)
REQ-036 Single winner: node 2 spikes every cycle, others never -> winner_o=2, win_count_o=8, tie_o=0, none_o=0, valid_o rises 12 edges after start.
REQ-037 Tie: nodes 1 and 3 spike 5 times each, node 0 spikes 2 times -> winner_o=1, win_count_o=5, tie_o=1.
REQ-038 Saturation (CNT_W=3): node 0 spikes all 8 cycles -> win_count_o=7 with no wrap; node 0 still wins over node 1 with 6 spikes.
REQ-039 No spikes -> none_o=1, winner_o=0, win_count_o=0, tie_o=0.
REQ-040 Backpressure: hold ready_i=0 for 5 cycles in DONE -> outputs stable, valid_o high 5 cycles, IDLE on the ready_i edge; start_i pulsed in COMPARE is ignored.
REQ-041 Reset at cycle 4 of COUNT -> all outputs 0 at once; a new window then gives counts from fresh spikes only.
